// File: rtl/dcache_flush_seq.sv
// ---------------------------------------------------------------------------
// dcache_flush_seq : walks every (set, way), writes back dirty lines, then
// invalidates each line before acknowledging the flush.     Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_flush_seq #(
   parameter  int NUM_SETS = 256,
   parameter  int NUM_WAYS = 4,
   localparam int IDX_W    = $clog2(NUM_SETS),
   localparam int WAY_W    = $clog2(NUM_WAYS)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   output logic             flush_ack_o,
   output logic             busy_o,
   output logic             tag_req_o,
   input  logic             tag_gnt_i,
   output logic [IDX_W-1:0] tag_idx_o,
   output logic [WAY_W-1:0] tag_way_o,
   input  logic             tag_valid_i,
   input  logic             tag_dirty_i,
   output logic             wb_req_o,
   input  logic             wb_ack_i,
   output logic             inv_we_o
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_READ  = 3'd1,
      S_CHECK = 3'd2,
      S_WB    = 3'd3,
      S_INV   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SETS - 1);
   localparam logic [WAY_W-1:0] LAST_WAY = WAY_W'(NUM_WAYS - 1);

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic [WAY_W-1:0] way;

   assign tag_idx_o = idx;
   assign tag_way_o = way;

   // Strobes are registered alongside the state, so each is high exactly
   // while the FSM sits in its owning state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= S_IDLE;
         idx         <= '0;
         way         <= '0;
         busy_o      <= 1'b0;
         tag_req_o   <= 1'b0;
         wb_req_o    <= 1'b0;
         inv_we_o    <= 1'b0;
         flush_ack_o <= 1'b0;
      end else begin
         busy_o      <= 1'b1;
         tag_req_o   <= 1'b0;
         wb_req_o    <= 1'b0;
         inv_we_o    <= 1'b0;
         flush_ack_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (flush_i) begin
                  idx       <= '0;
                  way       <= '0;
                  state     <= S_READ;
                  tag_req_o <= 1'b1;
               end else begin
                  busy_o    <= 1'b0;
               end
            end
            S_READ: begin
               if (tag_gnt_i) begin
                  state     <= S_CHECK;
               end else begin
                  tag_req_o <= 1'b1;
               end
            end
            S_CHECK: begin
               // Dirty only matters for a valid line.
               if (tag_valid_i && tag_dirty_i) begin
                  state    <= S_WB;
                  wb_req_o <= 1'b1;
               end else begin
                  state    <= S_INV;
                  inv_we_o <= 1'b1;
               end
            end
            S_WB: begin
               if (wb_ack_i) begin
                  state    <= S_INV;
                  inv_we_o <= 1'b1;
               end else begin
                  wb_req_o <= 1'b1;
               end
            end
            S_INV: begin
               if ((idx == LAST_IDX) && (way == LAST_WAY)) begin
                  state       <= S_DONE;
                  flush_ack_o <= 1'b1;
               end else begin
                  state     <= S_READ;
                  tag_req_o <= 1'b1;
                  way       <= way + 1'b1;
                  if (way == LAST_WAY) begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            S_DONE: begin
               state  <= S_IDLE;
               busy_o <= 1'b0;
            end
            default: begin
               state  <= S_IDLE;
               busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_dcache_flush_seq.sv
// ---------------------------------------------------------------------------
// tb_dcache_flush_seq : bench for dcache_flush_seq with 4 sets x 2 ways.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_dcache_flush_seq;

   localparam int NS = 4;
   localparam int NW = 2;
   localparam int NL = NS * NW;

   logic       clk = 1'b0;
   logic       rst;
   logic       flush;
   logic       flush_ack;
   logic       busy;
   logic       tag_req;
   logic       tag_gnt;
   logic [1:0] tag_idx;
   logic [0:0] tag_way;
   logic       tag_valid;
   logic       tag_dirty;
   logic       wb_req;
   logic       wb_ack;
   logic       inv_we;

   int tests = 0;
   int fails = 0;

   // Cache contents and per-line handshake timing seen by the sequencer
   bit m_valid [NL];
   bit m_dirty [NL];
   int m_stall [NL];
   int m_wbd   [NL];
   int used    [NL];
   bit spurious;

   int inv_q[$];
   int wb_line_q[$];
   int wb_len_q[$];
   int ack_cycles[$];
   int busy_cnt;
   int viol;
   logic [7:0] snap;

   always #5 clk = ~clk;

   dcache_flush_seq #(.NUM_SETS(NS), .NUM_WAYS(NW)) dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .flush_i     (flush),
      .flush_ack_o (flush_ack),
      .busy_o      (busy),
      .tag_req_o   (tag_req),
      .tag_gnt_i   (tag_gnt),
      .tag_idx_o   (tag_idx),
      .tag_way_o   (tag_way),
      .tag_valid_i (tag_valid),
      .tag_dirty_i (tag_dirty),
      .wb_req_o    (wb_req),
      .wb_ack_i    (wb_ack),
      .inv_we_o    (inv_we)
   );

   function automatic int out_vec();
      return {24'd0, busy, tag_req, wb_req, inv_we, flush_ack, tag_idx, tag_way};
   endfunction

   // Reference latency: IDLE cycle + per line (READ, CHECK, INV + stalls
   // + optional writeback of 1 + wait cycles) + DONE cycle.
   function automatic int exp_ack();
      int s = 1;
      for (int l = 0; l < NL; l++) begin
         s += 3 + m_stall[l];
         if (m_valid[l] && m_dirty[l]) s += 1 + m_wbd[l];
      end
      return s + 1;
   endfunction

   task automatic clear_mem();
      for (int l = 0; l < NL; l++) begin
         m_valid[l] = 1'b0;
         m_dirty[l] = 1'b0;
         m_stall[l] = 0;
         m_wbd[l]   = 0;
      end
      spurious = 1'b0;
   endtask

   task automatic idle_tail(input int n, output int active);
      active = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (busy || flush_ack || tag_req || wb_req || inv_we) active++;
      end
   endtask

   // Raises flush and plays the tag-array / writeback partner each cycle,
   // logging what the sequencer does. Cycle 1 is the first cycle flush is high.
   task automatic run_walk(input int drop_after, input int acks_wanted,
                           input int abort_line, input int budget,
                           output bit aborted);
      int cyc, wbcnt, wblen, cur, prev_line;
      bit gnt_pend, prev_wb, prev_stall;
      inv_q.delete(); wb_line_q.delete(); wb_len_q.delete(); ack_cycles.delete();
      busy_cnt = 0; viol = 0; aborted = 1'b0;
      for (int l = 0; l < NL; l++) used[l] = 0;
      wbcnt = 0; wblen = 0; gnt_pend = 1'b0; prev_wb = 1'b0; prev_stall = 1'b0;
      prev_line = 0;
      @(negedge clk);
      flush     = 1'b1;
      tag_gnt   = 1'($urandom_range(1));
      tag_valid = 1'($urandom_range(1));
      tag_dirty = 1'($urandom_range(1));
      wb_ack    = 1'b0;
      cyc = 1;
      while (ack_cycles.size() < acks_wanted && cyc < budget) begin
         @(negedge clk);
         cyc++;
         cur = int'(tag_idx) * NW + int'(tag_way);
         if (busy) busy_cnt++;
         if (int'(tag_req) + int'(wb_req) + int'(inv_we) + int'(flush_ack) > 1) viol++;
         if ((tag_req || wb_req || inv_we || flush_ack) && !busy) viol++;
         if (prev_stall && cur != prev_line) viol++;
         if (prev_wb && wb_req && cur != prev_line) viol++;
         if (inv_we) inv_q.push_back(cur);
         if (wb_req && !prev_wb) begin
            wb_line_q.push_back(cur);
            wblen = 0;
         end
         if (wb_req) wblen++;
         if (!wb_req && prev_wb) wb_len_q.push_back(wblen);
         if (flush_ack) ack_cycles.push_back(cyc);
         if (abort_line >= 0 && wb_req && cur == abort_line) begin
            flush = 1'b0;
            rst   = 1'b1;
            #1;
            snap    = 8'(out_vec());
            aborted = 1'b1;
            return;
         end
         prev_wb    = wb_req;
         prev_line  = cur;
         prev_stall = 1'b0;
         if (tag_req) begin
            if (used[cur] < m_stall[cur]) begin
               used[cur]++;
               tag_gnt    = 1'b0;
               prev_stall = 1'b1;
               gnt_pend   = 1'b0;
               tag_valid  = 1'($urandom_range(1));
               tag_dirty  = 1'($urandom_range(1));
            end else begin
               tag_gnt   = 1'b1;
               tag_valid = m_valid[cur];
               tag_dirty = m_dirty[cur];
               gnt_pend  = 1'b1;
            end
         end else begin
            tag_gnt = 1'($urandom_range(1));
            if (gnt_pend) begin
               gnt_pend = 1'b0;
            end else begin
               tag_valid = 1'($urandom_range(1));
               tag_dirty = 1'($urandom_range(1));
            end
         end
         if (wb_req) begin
            wbcnt++;
            wb_ack = (wbcnt == m_wbd[cur] + 1);
         end else begin
            wbcnt  = 0;
            wb_ack = spurious && ($urandom_range(3) == 0);
         end
         if (drop_after > 0 && cyc >= drop_after) flush = 1'b0;
         if (ack_cycles.size() == acks_wanted) flush = 1'b0;
      end
      flush  = 1'b0;
      wb_ack = 1'b0;
   endtask

   task automatic test_reset();
      int active;
      rst = 1'b1; flush = 1'b0; tag_gnt = 1'b0; tag_valid = 1'b0;
      tag_dirty = 1'b0; wb_ack = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (out_vec() !== 0) begin
         fails++;
         $display("FAIL reset_outputs: got %08b required 00000000", out_vec());
      end
      rst = 1'b0;
      idle_tail(4, active);
      tests++;
      if (active !== 0) begin
         fails++;
         $display("FAIL reset_idle: got %0d active cycles required 0", active);
      end
   endtask

   task automatic test_clean();
      bit ab; int bad, active;
      clear_mem();
      m_valid[1] = 1'b1; m_valid[6] = 1'b1;
      run_walk(0, 1, -1, 400, ab);
      tests++;
      if (ack_cycles.size() !== 1 || ack_cycles[0] !== 26) begin
         fails++;
         $display("FAIL clean_ack: got %0d acks first at %0d required 1 at 26",
                  ack_cycles.size(), ack_cycles.size() > 0 ? ack_cycles[0] : -1);
      end
      bad = -1;
      for (int k = 0; k < NL; k++)
         if (bad < 0 && (k >= inv_q.size() || inv_q[k] != k)) bad = k;
      tests++;
      if (inv_q.size() !== NL || bad !== -1) begin
         fails++;
         $display("FAIL clean_inv_order: got %0d pulses first bad %0d required %0d in order",
                  inv_q.size(), bad, NL);
      end
      tests++;
      if (wb_line_q.size() !== 0) begin
         fails++;
         $display("FAIL clean_no_wb: got %0d wb episodes required 0", wb_line_q.size());
      end
      tests++;
      if (busy_cnt !== 25 || viol !== 0) begin
         fails++;
         $display("FAIL clean_busy: got busy %0d viol %0d required 25 and 0", busy_cnt, viol);
      end
      idle_tail(4, active);
      tests++;
      if (active !== 0) begin
         fails++;
         $display("FAIL clean_tail: got %0d active cycles required 0", active);
      end
   endtask

   task automatic test_dirty_line();
      bit ab;
      clear_mem();
      m_valid[5] = 1'b1; m_dirty[5] = 1'b1; m_wbd[5] = 3;
      run_walk(0, 1, -1, 400, ab);
      tests++;
      if (wb_line_q.size() !== 1 || wb_line_q[0] !== 5 || wb_len_q.size() !== 1 || wb_len_q[0] !== 4) begin
         fails++;
         $display("FAIL dirty_wb: got %0d episodes line %0d len %0d required 1 line 5 len 4",
                  wb_line_q.size(), wb_line_q.size() > 0 ? wb_line_q[0] : -1,
                  wb_len_q.size() > 0 ? wb_len_q[0] : -1);
      end
      tests++;
      if (ack_cycles.size() !== 1 || ack_cycles[0] !== 30 || inv_q.size() !== NL) begin
         fails++;
         $display("FAIL dirty_ack: got ack at %0d inv %0d required 30 and %0d",
                  ack_cycles.size() > 0 ? ack_cycles[0] : -1, inv_q.size(), NL);
      end
   endtask

   task automatic test_clean_and_invalid_dirty();
      bit ab;
      clear_mem();
      m_valid[1] = 1'b1;
      m_dirty[6] = 1'b1; m_wbd[6] = 2;
      spurious = 1'b1;
      run_walk(0, 1, -1, 400, ab);
      tests++;
      if (wb_line_q.size() !== 0 || inv_q.size() !== NL || inv_q[1] !== 1 || inv_q[6] !== 6) begin
         fails++;
         $display("FAIL nodirty_wb: got %0d wb %0d inv required 0 wb %0d inv",
                  wb_line_q.size(), inv_q.size(), NL);
      end
      tests++;
      if (ack_cycles.size() !== 1 || ack_cycles[0] !== 26) begin
         fails++;
         $display("FAIL nodirty_ack: got %0d required 26",
                  ack_cycles.size() > 0 ? ack_cycles[0] : -1);
      end
   endtask

   task automatic test_grant_stall();
      bit ab;
      clear_mem();
      m_stall[2] = 5;
      run_walk(0, 1, -1, 400, ab);
      tests++;
      if (ack_cycles.size() !== 1 || ack_cycles[0] !== 31) begin
         fails++;
         $display("FAIL stall_ack: got %0d required 31",
                  ack_cycles.size() > 0 ? ack_cycles[0] : -1);
      end
      tests++;
      if (viol !== 0 || inv_q.size() !== NL) begin
         fails++;
         $display("FAIL stall_steady: got viol %0d inv %0d required 0 and %0d",
                  viol, inv_q.size(), NL);
      end
   endtask

   task automatic test_reset_midwalk();
      bit ab; int active;
      clear_mem();
      m_valid[4] = 1'b1; m_dirty[4] = 1'b1; m_wbd[4] = 10;
      run_walk(0, 1, 4, 400, ab);
      tests++;
      if (ab !== 1'b1 || snap !== 8'd0 || ack_cycles.size() !== 0) begin
         fails++;
         $display("FAIL midreset_outputs: got aborted %0d outputs %08b acks %0d required 1 00000000 0",
                  ab, snap, ack_cycles.size());
      end
      idle_tail(2, active);
      rst = 1'b0;
      tests++;
      if (active !== 0) begin
         fails++;
         $display("FAIL midreset_hold: got %0d active cycles required 0", active);
      end
      m_wbd[4] = 2;
      run_walk(0, 1, -1, 400, ab);
      tests++;
      if (ack_cycles.size() !== 1 || ack_cycles[0] !== 29 || inv_q.size() !== NL || inv_q[0] !== 0) begin
         fails++;
         $display("FAIL midreset_restart: got ack %0d inv %0d first %0d required 29 %0d 0",
                  ack_cycles.size() > 0 ? ack_cycles[0] : -1, inv_q.size(),
                  inv_q.size() > 0 ? inv_q[0] : -1, NL);
      end
      idle_tail(4, active);
      tests++;
      if (active !== 0) begin
         fails++;
         $display("FAIL midreset_single_ack: got %0d active cycles after ack required 0", active);
      end
   endtask

   task automatic test_flush_drop();
      bit ab; int active;
      clear_mem();
      run_walk(3, 1, -1, 400, ab);
      tests++;
      if (ack_cycles.size() !== 1 || ack_cycles[0] !== 26 || inv_q.size() !== NL) begin
         fails++;
         $display("FAIL drop_ack: got ack %0d inv %0d required 26 %0d",
                  ack_cycles.size() > 0 ? ack_cycles[0] : -1, inv_q.size(), NL);
      end
      idle_tail(4, active);
      tests++;
      if (active !== 0) begin
         fails++;
         $display("FAIL drop_tail: got %0d active cycles required 0", active);
      end
   endtask

   task automatic test_back_to_back();
      bit ab;
      clear_mem();
      run_walk(0, 2, -1, 400, ab);
      tests++;
      if (ack_cycles.size() !== 2 || ack_cycles[1] !== 52 || inv_q.size() !== 2 * NL) begin
         fails++;
         $display("FAIL b2b_ack: got %0d acks second %0d inv %0d required 2 52 %0d",
                  ack_cycles.size(), ack_cycles.size() > 1 ? ack_cycles[1] : -1,
                  inv_q.size(), 2 * NL);
      end
   endtask

   task automatic test_random();
      bit ab; int bad, exp_wb[$], exp_len[$], active;
      for (int it = 0; it < 6; it++) begin
         spurious = 1'b1;
         exp_wb.delete(); exp_len.delete();
         for (int l = 0; l < NL; l++) begin
            m_valid[l] = 1'($urandom_range(1));
            m_dirty[l] = 1'($urandom_range(1));
            m_stall[l] = int'($urandom_range(3));
            m_wbd[l]   = int'($urandom_range(4));
            if (m_valid[l] && m_dirty[l]) begin
               exp_wb.push_back(l);
               exp_len.push_back(m_wbd[l] + 1);
            end
         end
         run_walk(0, 1, -1, 400, ab);
         tests++;
         if (ack_cycles.size() !== 1 || ack_cycles[0] !== exp_ack() || viol !== 0) begin
            fails++;
            $display("FAIL rand%0d_ack: got ack %0d viol %0d required %0d 0", it,
                     ack_cycles.size() > 0 ? ack_cycles[0] : -1, viol, exp_ack());
         end
         bad = -1;
         for (int k = 0; k < exp_wb.size(); k++)
            if (bad < 0 && (k >= wb_line_q.size() || k >= wb_len_q.size() ||
                            wb_line_q[k] != exp_wb[k] || wb_len_q[k] != exp_len[k])) bad = k;
         tests++;
         if (wb_line_q.size() !== exp_wb.size() || bad !== -1) begin
            fails++;
            $display("FAIL rand%0d_wb: got %0d episodes first bad %0d required %0d", it,
                     wb_line_q.size(), bad, exp_wb.size());
         end
         bad = -1;
         for (int k = 0; k < NL; k++)
            if (bad < 0 && (k >= inv_q.size() || inv_q[k] != k)) bad = k;
         tests++;
         if (inv_q.size() !== NL || bad !== -1) begin
            fails++;
            $display("FAIL rand%0d_inv: got %0d pulses first bad %0d required %0d", it,
                     inv_q.size(), bad, NL);
         end
         idle_tail(2, active);
      end
   endtask

   initial begin
      test_reset();
      test_clean();
      test_dirty_line();
      test_clean_and_invalid_dirty();
      test_grant_stall();
      test_reset_midwalk();
      test_flush_drop();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
